// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes over a 128-bit state.
// LANES byte substituters per cycle and 16/LANES cycles per block.
// Valid/ready handshakes on the input and output sides.
// Optional macro INV_SBOX_EN adds an inverse S-box per lane, selected per block by inv_i.
module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] state_i,
  input  logic         inv_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
);

  localparam int unsigned STEPS = (LANES == 0) ? 1 : 16 / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Only power-of-two lane counts that divide the state evenly are legal
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef INV_SBOX_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  fsm_e             fsm_q, fsm_d;
  logic [127:0]     work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       byte_idx;
  logic [6:0]       bit_pos;
  logic [7:0]       lane_in;
  logic [7:0]       lane_out;

`ifdef INV_SBOX_EN
  logic mode_q, mode_d;
`else
  // Forward-only build: the mode is constantly forward, so inv_i has no sink
  logic unused_inv;
  assign unused_inv = inv_i;
`endif

  // Next-state, working register update and lane substitution
  always_comb begin
    fsm_d    = fsm_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    byte_idx = '0;
    bit_pos  = '0;
    lane_in  = '0;
    lane_out = '0;
`ifdef INV_SBOX_EN
    mode_d   = mode_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (valid_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = BUSY;
`ifdef INV_SBOX_EN
          mode_d = inv_i;
`endif
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          byte_idx = 5'(cnt_q) * 5'(LANES) + 5'(l);
          bit_pos  = {byte_idx[3:0], 3'b000};
          lane_in  = work_q[bit_pos +: 8];
`ifdef INV_SBOX_EN
          lane_out = mode_q ? SBOX_INV[lane_in] : SBOX_FWD[lane_in];
`else
          lane_out = SBOX_FWD[lane_in];
`endif
          work_d[bit_pos +: 8] = lane_out;
        end
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State, working register, counter and mode flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      work_q <= '0;
      cnt_q  <= '0;
`ifdef INV_SBOX_EN
      mode_q <= 1'b0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
`ifdef INV_SBOX_EN
      mode_q <= mode_d;
`endif
    end
  end

  // Outputs come straight from the FSM state and working register
  assign ready_o = (fsm_q == IDLE);
  assign valid_o = (fsm_q == DONE);
  assign busy_o  = (fsm_q != IDLE);
  assign state_o = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: scoreboard bench for sub_bytes_iter.
// The expected results come from an algebraic GF(2^8) S-box model.
module tb_sub_bytes_iter #(
  parameter int unsigned LANES = 4
);

  localparam int unsigned STEPS = 16 / LANES;
`ifdef INV_SBOX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] VEC_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_SB = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] state_i;
  logic         inv_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] state_o;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int last_hs_edge  = 0;
  int last_acc_edge = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];

  sub_bytes_iter #(.LANES(LANES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .state_i(state_i),
    .inv_i  (inv_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .state_o(state_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sb_fwd(input logic [7:0] b);
    logic [7:0] s;
    s = ginv(b);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sb_inv(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[k*8 +: 8] = (inv && INV_EN) ? sb_inv(s[k*8 +: 8]) : sb_fwd(s[k*8 +: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a block, push its expectation at the accepting edge, then scramble the inputs
  task automatic drive_block(input logic [127:0] data, input logic inv,
                             input logic [127:0] exp, input bit keep_valid);
    bit accepted;
    accepted = 1'b0;
    valid_i = 1'b1;
    state_i = data;
    inv_i   = inv;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (ready_o) begin
        accepted = 1'b1;
        exp_q.push_back(exp);
        acc_q.push_back(edges + 1);
        last_acc_edge = edges + 1;
      end
    end
    if (!accepted) check("accept_timeout", 128'(ready_o), 128'(1));
    @(posedge clk);
    #1;
    if (!keep_valid) valid_i = 1'b0;
    state_i = rand128();
    inv_i   = ~inv;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ready_o && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    if (!seen) check("valid_timeout", 128'(valid_o), 128'(1));
  endtask

  // Monitor: handshake flags against a model, latency, hold stability and scoreboard pops
  logic         inflight   = 1'b0;
  logic         prev_valid = 1'b0;
  logic [127:0] prev_state = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("busy", 128'(busy_o), 128'(inflight));
      check("ready", 128'(ready_o), 128'(!inflight));
      if (valid_o && !prev_valid) begin
        if (acc_q.size() == 0) check("spurious_valid", 128'(valid_o), 128'(0));
        else check("latency", 128'(edges - acc_q.pop_front()), 128'(STEPS));
      end
      if (valid_o && prev_valid) check("hold", state_o, prev_state);
      if (valid_o && ready_i) begin
        if (exp_q.size() != 0) check("result", state_o, exp_q.pop_front());
        last_hs_edge = edges + 1;
      end
      if (!inflight) begin
        if (valid_i) inflight = 1'b1;
      end else if (valid_o && ready_i) begin
        inflight = 1'b0;
      end
      prev_valid = valid_o;
      prev_state = state_o;
    end
  end

  logic [127:0] blk_a;
  logic [127:0] blk_b;
  logic         rinv;

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    state_i = '0;
    inv_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_state", state_o, 128'(0));
    check("rst_ready", 128'(ready_o), 128'(1));
    check("rst_busy", 128'(busy_o), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero state
    drive_block('0, 1'b0, {16{8'h63}}, 1'b0);
    wait_idle();

    // Known vector
    drive_block(VEC_PT, 1'b0, VEC_SB, 1'b0);
    wait_idle();

    // Output stall for 5 cycles in DONE
    ready_i = 1'b0;
    drive_block(VEC_PT, 1'b0, VEC_SB, 1'b0);
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    check("stall_valid", 128'(valid_o), 128'(1));
    check("stall_state", state_o, VEC_SB);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_ready", 128'(ready_o), 128'(1));
    check("post_hs_valid", 128'(valid_o), 128'(0));

    // Asynchronous reset in the middle of BUSY aborts the block
    blk_a = rand128();
    drive_block(blk_a, 1'b0, model(blk_a, 1'b0), 1'b0);
    repeat ((STEPS > 3) ? 3 : STEPS - 1) @(posedge clk);
    #2;
    check("abort_busy", 128'(busy_o), 128'(1));
    rst_n = 1'b0;
    #1;
    check("abort_valid", 128'(valid_o), 128'(0));
    check("abort_state", state_o, 128'(0));
    check("abort_ready", 128'(ready_o), 128'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_valid", 128'(valid_o), 128'(0));
    blk_a = rand128();
    drive_block(blk_a, 1'b0, model(blk_a, 1'b0), 1'b0);
    wait_idle();

    // Inverse requests: inverse image when built in, forward image otherwise
    drive_block(VEC_SB, 1'b1, INV_EN ? VEC_PT : model(VEC_SB, 1'b0), 1'b0);
    wait_idle();
    drive_block('0, 1'b1, INV_EN ? {16{8'h52}} : {16{8'h63}}, 1'b0);
    wait_idle();

    // Back-to-back blocks with valid_i held high
    blk_a = rand128();
    blk_b = rand128();
    drive_block(blk_a, 1'b0, model(blk_a, 1'b0), 1'b1);
    drive_block(blk_b, 1'b0, model(blk_b, 1'b0), 1'b0);
    check("b2b_gap", 128'(last_acc_edge), 128'(last_hs_edge + 1));
    wait_idle();

    // Random blocks with random mode
    for (int i = 0; i < 6; i++) begin
      blk_a = rand128();
      rinv  = 1'($urandom_range(0, 1));
      drive_block(blk_a, rinv, model(blk_a, rinv), 1'b0);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Parametrised, area-scalable successor to the fully parallel SubBytes stage.
- Applies the AES S-box to a 128-bit state using LANES byte substituters per cycle, iterating over the 16 bytes in 16/LANES cycles.
- Uses valid/ready handshakes on input and output, so it can sit in iterative or low-area AES round datapaths with backpressure.
- Inverse S-box (decrypt) support is compile-time optional.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- STEPS, 16/LANES (derived localparam, not overridable), number of substitution cycles per block.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  input block valid.
- ready_o  output  1  block can accept input; equals (fsm == IDLE).
- state_i  input  128  input state; byte k = state_i[k*8 +: 8].
- inv_i  input  1  1 = inverse S-box, 0 = forward S-box; sampled at acceptance.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- state_o  output  128  result state; mirrors the working register.
- busy_o  output  1  high in BUSY or DONE.

Behaviour:
- One clock (clk). Asynchronous active-low reset (rst_n).
- Reset values: fsm=IDLE, working reg=0, step counter=0, mode reg=0. Outputs: valid_o=0, state_o=0, busy_o=0, ready_o=1.
- Reset asserted mid-operation aborts the block immediately. No partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On valid_i && ready_o, capture state_i into the working reg and inv_i into the mode reg.
  - Set counter to 0 and go to BUSY.
  - Without valid_i, stay in IDLE.
- BUSY:
  - Each cycle, bytes [cnt*LANES, cnt*LANES+LANES-1] of the working reg are replaced in place by their S-box (or inverse) image.
  - Lowest bytes are processed first. Counter increments.
  - After the substitution with cnt == STEPS-1, go to DONE and clear the counter.
- DONE:
  - valid_o=1 and state_o holds the full substituted state.
  - valid_o and state_o are held stable until ready_i=1, then go to IDLE.
  - valid_o can drop only after a completed handshake.
- Latency: valid_o rises STEPS clock edges after the accepting edge. For LANES=16, this is 1 cycle, matching the parallel stage.
- Throughput: ready_o is low in BUSY and DONE, so the earliest next acceptance is the cycle after the output handshake.
- Changes on state_i or inv_i after acceptance have no effect on the block in flight.
- ready_i while not in DONE is ignored. valid_i while ready_o=0 is ignored; upstream holds it.
- Counter width is $clog2(STEPS) with a minimum of 1 bit. For LANES=16 the counter is unused, and BUSY lasts exactly one cycle.
- S-box lanes are purely combinational per byte. All outputs are registered or derived directly from the FSM state.

Optional Feature:
- Macro: INV_SBOX_EN.
- Defined: each lane also instantiates an inverse S-box. The mode reg selects inverse (1) or forward (0) per block.
- Undefined: no inverse logic is built. inv_i is ignored, the mode reg is tied to 0, and every block uses the forward S-box.

Test Plan:
- LANES=16, state_i=128'h0, inv_i=0 -> valid_o exactly 1 cycle after acceptance, state_o=128'h6363...63 (16 bytes of 63).
- LANES=4, state_i=128'h00112233445566778899aabbccddeeff -> valid_o 4 cycles after acceptance, state_o=128'h638293c31bfc33f5c4eeacea4bc12816. ready_o=0 and busy_o=1 from acceptance until the output handshake.
- LANES=1, same vector, ready_i held 0 for 5 cycles in DONE -> valid_o rises 16 cycles after acceptance. valid_o and state_o stay stable through the stall. After ready_i=1: IDLE and ready_o=1 next cycle.
- LANES=2, pulse rst_n low for 1 cycle during BUSY (step 3) -> asynchronous return to valid_o=0, state_o=0, ready_o=1. No valid_o for the aborted block. A new block afterwards completes correctly.
- INV_SBOX_EN defined, LANES=8, inv_i=1, state_i=128'h638293c31bfc33f5c4eeacea4bc12816 -> state_o=128'h00112233445566778899aabbccddeeff after 2 cycles. INV_SBOX_EN undefined, same stimulus -> forward result, e.g. input 128'h0 with inv_i=1 gives all 63.
- Back-to-back, LANES=4, valid_i held high with two blocks and ready_i=1 -> second acceptance occurs the cycle after the first handshake. Both results are correct, and the second block is unaffected by changes to state_i made after its acceptance.
